// File: rtl/trigger_link_bringup_ctrl.sv
// Trigger-link TX bring-up sequencer: steps the GTP common PLL through power-down,
// reset and lock, releases the TX lanes, then supervises lock with retry/fault handling.
module trigger_link_bringup_ctrl #(
  parameter int ILINKS       = 4,
  parameter int PDCNT        = 96,
  parameter int RSTCNT       = 128,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int TXRSTCNT     = 16,
  parameter int DONE_TIMEOUT = 4096,
  parameter int MAX_RETRIES  = 7
) (
  input  logic              clk_40,
  input  logic              reset_i,
  input  logic              pll_lock_i,
  input  logic              pll_refclklost_i,
  input  logic              mmcm_lock_i,
  input  logic [ILINKS-1:0] tx_resetdone_i,
  input  logic [ILINKS-1:0] link_enable_i,
  output logic              pll_powerdown_o,
  output logic              pll_reset_o,
  output logic              tx_reset_o,
  output logic              ready_o,
  output logic              fault_o,
  output logic [2:0]        state_o,
  output logic [3:0]        retry_cnt_o,
  output logic [15:0]       lock_loss_cnt_o
);

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_PLLRST    = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_TXRST     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_READY     = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [15:0] PD_LAST    = 16'(PDCNT - 1);
  localparam logic [15:0] RST_LAST   = 16'(RSTCNT - 1);
  localparam logic [15:0] STAB_LAST  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] TXRST_LAST = 16'(TXRSTCNT - 1);
  localparam logic [15:0] DONE_LAST  = 16'(DONE_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

  state_t      state_q, state_nxt;
  logic [15:0] timer_q, timer_nxt;
  logic [15:0] stab_q, stab_nxt;
  logic [3:0]  retry_q, retry_nxt;
  logic [15:0] lloss_q, lloss_nxt;
  logic        pd_nxt, pr_nxt, tr_nxt, rdy_nxt, flt_nxt;
  logic        locked;
  logic        lanes_done;
  logic        go_timeout;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign locked     = pll_lock_i & mmcm_lock_i & ~pll_refclklost_i;
  // A disabled lane counts as done, so an all-disabled mask passes straight through.
  assign lanes_done = &(tx_resetdone_i | ~link_enable_i);

  // State and control register
  always_ff @(posedge clk_40) begin
    if (reset_i) begin
      state_q         <= ST_PWRDN;
      timer_q         <= '0;
      stab_q          <= '0;
      retry_q         <= '0;
      lloss_q         <= '0;
      pll_powerdown_o <= 1'b1;
      pll_reset_o     <= 1'b1;
      tx_reset_o      <= 1'b1;
      ready_o         <= 1'b0;
      fault_o         <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      timer_q         <= timer_nxt;
      stab_q          <= stab_nxt;
      retry_q         <= retry_nxt;
      lloss_q         <= lloss_nxt;
      pll_powerdown_o <= pd_nxt;
      pll_reset_o     <= pr_nxt;
      tx_reset_o      <= tr_nxt;
      ready_o         <= rdy_nxt;
      fault_o         <= flt_nxt;
    end
  end

  // Next-state, retry and lock-loss bookkeeping
  always_comb begin
    state_nxt  = state_q;
    retry_nxt  = retry_q;
    lloss_nxt  = lloss_q;
    go_timeout = 1'b0;
    case (state_q)
      ST_PWRDN:     if (timer_q == PD_LAST) state_nxt = ST_PLLRST;
      ST_PLLRST:    if (timer_q == RST_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        // Stability reached on the timeout cycle still counts as success.
        if (locked && (stab_q == STAB_LAST)) state_nxt = ST_TXRST;
        else if (timer_q == LOCK_LAST)       go_timeout = 1'b1;
      end
      ST_TXRST:     if (timer_q == TXRST_LAST) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (lanes_done)                state_nxt = ST_READY;
        else if (timer_q == DONE_LAST) go_timeout = 1'b1;
      end
      ST_READY: begin
        if (!locked) begin
          state_nxt = ST_PLLRST;
          lloss_nxt = sat_inc16(lloss_q);
        end
      end
      ST_FAULT:     state_nxt = ST_FAULT;
      default:      state_nxt = ST_PWRDN;
    endcase

    if (go_timeout) begin
      if (retry_q == RETRY_MAX) begin
        state_nxt = ST_FAULT;
      end else begin
        retry_nxt = retry_q + 4'd1;
        state_nxt = ST_PWRDN;
      end
    end

    if ((state_nxt == ST_READY) && (state_q != ST_READY)) retry_nxt = '0;
  end

  always_comb begin
    timer_nxt = (state_nxt != state_q) ? 16'd0 : sat_inc16(timer_q);
    stab_nxt  = '0;
    if ((state_q == ST_WAIT_LOCK) && (state_nxt == ST_WAIT_LOCK) && locked)
      stab_nxt = stab_q + 16'd1;
  end

  // Output decode from the next state so the registered outputs track state_q
  always_comb begin
    pd_nxt  = 1'b0;
    pr_nxt  = 1'b0;
    tr_nxt  = 1'b0;
    rdy_nxt = 1'b0;
    flt_nxt = 1'b0;
    case (state_nxt)
      ST_PWRDN:     begin pd_nxt = 1'b1; pr_nxt = 1'b1; tr_nxt = 1'b1; end
      ST_PLLRST:    begin pr_nxt = 1'b1; tr_nxt = 1'b1; end
      ST_WAIT_LOCK: tr_nxt = 1'b1;
      ST_TXRST:     tr_nxt = 1'b1;
      ST_WAIT_DONE: tr_nxt = 1'b0;
      ST_READY:     rdy_nxt = 1'b1;
      ST_FAULT:     begin pd_nxt = 1'b1; pr_nxt = 1'b1; tr_nxt = 1'b1; flt_nxt = 1'b1; end
      default:      begin pd_nxt = 1'b1; pr_nxt = 1'b1; tr_nxt = 1'b1; end
    endcase
  end

  assign state_o         = state_q;
  assign retry_cnt_o     = retry_q;
  assign lock_loss_cnt_o = lloss_q;

endmodule

// File: tb/tb_trigger_link_bringup_ctrl.sv
// Scoreboard bench for trigger_link_bringup_ctrl: directed stimulus pushes expected
// state-change events; a negedge monitor pops and compares them as state_o moves.
module tb_trigger_link_bringup_ctrl;

  localparam int ILINKS       = 4;
  localparam int PDCNT        = 96;
  localparam int RSTCNT       = 128;
  localparam int LOCK_STABLE  = 16;
  localparam int LOCK_TIMEOUT = 64;
  localparam int TXRSTCNT     = 16;
  localparam int DONE_TIMEOUT = 64;
  localparam int MAX_RETRIES  = 2;

  typedef struct packed {
    logic [2:0]  st;
    logic        pd;
    logic        pr;
    logic        tr;
    logic        rdy;
    logic        flt;
    logic [3:0]  retry;
    logic [15:0] ll;
    logic [31:0] cyc;
  } ev_t;

  logic              clk_40;
  logic              reset_i;
  logic              pll_lock_i;
  logic              pll_refclklost_i;
  logic              mmcm_lock_i;
  logic [ILINKS-1:0] tx_resetdone_i;
  logic [ILINKS-1:0] link_enable_i;
  logic              pll_powerdown_o;
  logic              pll_reset_o;
  logic              tx_reset_o;
  logic              ready_o;
  logic              fault_o;
  logic [2:0]        state_o;
  logic [3:0]        retry_cnt_o;
  logic [15:0]       lock_loss_cnt_o;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  trigger_link_bringup_ctrl #(
    .ILINKS(ILINKS), .PDCNT(PDCNT), .RSTCNT(RSTCNT), .LOCK_STABLE(LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .TXRSTCNT(TXRSTCNT), .DONE_TIMEOUT(DONE_TIMEOUT),
    .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk_40(clk_40), .reset_i(reset_i), .pll_lock_i(pll_lock_i),
    .pll_refclklost_i(pll_refclklost_i), .mmcm_lock_i(mmcm_lock_i),
    .tx_resetdone_i(tx_resetdone_i), .link_enable_i(link_enable_i),
    .pll_powerdown_o(pll_powerdown_o), .pll_reset_o(pll_reset_o), .tx_reset_o(tx_reset_o),
    .ready_o(ready_o), .fault_o(fault_o), .state_o(state_o), .retry_cnt_o(retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  initial begin
    clk_40 = 1'b0;
    forever #5 clk_40 = ~clk_40;
  end

  always @(posedge clk_40) cyc <= cyc + 1;

  // Expected output levels per state, straight from the state table.
  function automatic ev_t mk(input int st, input int c, input int retry, input int ll);
    ev_t e;
    e.st = 3'(st);
    {e.pd, e.pr, e.tr, e.rdy, e.flt} = 5'b11100;
    case (st)
      1:       {e.pd, e.pr, e.tr, e.rdy, e.flt} = 5'b01100;
      2, 3:    {e.pd, e.pr, e.tr, e.rdy, e.flt} = 5'b00100;
      4:       {e.pd, e.pr, e.tr, e.rdy, e.flt} = 5'b00000;
      5:       {e.pd, e.pr, e.tr, e.rdy, e.flt} = 5'b00010;
      6:       {e.pd, e.pr, e.tr, e.rdy, e.flt} = 5'b11101;
      default: {e.pd, e.pr, e.tr, e.rdy, e.flt} = 5'b11100;
    endcase
    e.retry = 4'(retry);
    e.ll    = 16'(ll);
    e.cyc   = 32'(c);
    return e;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("st=%0d pd=%0b pr=%0b tr=%0b rdy=%0b flt=%0b retry=%0d ll=%0d cyc=%0d",
                     e.st, e.pd, e.pr, e.tr, e.rdy, e.flt, e.retry, e.ll, e.cyc);
  endfunction

  task automatic expect_ev(input int st, input int c, input int retry, input int ll);
    exp_q.push_back(mk(st, c, retry, ll));
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk_40);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk_40);
      #1;
      n++;
      if (n > budget) begin
        $display("FAIL drain_timeout: pending=%0d after %0d cycles, required 0", exp_q.size(), budget);
        $fatal(1, "scoreboard stalled");
      end
    end
  endtask

  task automatic pulse_refclklost(input int p);
    pll_refclklost_i = 1'b1;
    step_to(p + 1);
    pll_refclklost_i = 1'b0;
  endtask

  // Monitor: compares every state change against the queue head, flags late events,
  // and checks that outputs hold steady between state changes.
  initial begin
    ev_t        act;
    ev_t        e;
    ev_t        last;
    logic [2:0] prev;
    bit         seen;
    prev = 3'd7;
    seen = 1'b0;
    last = '0;
    forever begin
      @(negedge clk_40);
      act.st    = state_o;
      act.pd    = pll_powerdown_o;
      act.pr    = pll_reset_o;
      act.tr    = tx_reset_o;
      act.rdy   = ready_o;
      act.flt   = fault_o;
      act.retry = retry_cnt_o;
      act.ll    = lock_loss_cnt_o;
      act.cyc   = 32'(cyc);
      if (act.st !== prev) begin
        prev = act.st;
        seen = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: actual %s, required no event", fmt(act));
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL event_check: actual %s, required %s", fmt(act), fmt(e));
          end
        end
        last = act;
      end else begin
        if ((exp_q.size() != 0) && (act.cyc > exp_q[0].cyc)) begin
          n_checks++;
          n_fail++;
          e = exp_q.pop_front();
          $display("FAIL missing_event: actual %s, required %s", fmt(act), fmt(e));
        end
        if (seen) begin
          n_checks++;
          act.cyc = last.cyc;
          if (act !== last) begin
            n_fail++;
            $display("FAIL output_hold: actual %s, required %s", fmt(act), fmt(last));
            last = act;
          end
        end
      end
    end
  end

  initial begin
    int r;
    int p;
    int w;
    reset_i          = 1'b1;
    pll_lock_i       = 1'b1;
    pll_refclklost_i = 1'b0;
    mmcm_lock_i      = 1'b1;
    tx_resetdone_i   = 4'hF;
    link_enable_i    = 4'hF;

    // Reset state, then a clean bring-up
    expect_ev(0, 1, 0, 0);
    step_to(3);
    reset_i = 1'b0;
    r = cyc;
    expect_ev(1, r + 96, 0, 0);
    expect_ev(2, r + 224, 0, 0);
    expect_ev(3, r + 240, 0, 0);
    expect_ev(4, r + 256, 0, 0);
    expect_ev(5, r + 257, 0, 0);
    drain(400);

    // Refclk-lost pulse while READY
    p = cyc;
    expect_ev(1, p + 1, 0, 1);
    expect_ev(2, p + 129, 0, 1);
    expect_ev(3, p + 145, 0, 1);
    expect_ev(4, p + 161, 0, 1);
    expect_ev(5, p + 162, 0, 1);
    pulse_refclklost(p);
    drain(300);

    // Lock glitch at stability count 10
    p = cyc;
    w = p + 129;
    expect_ev(1, p + 1, 0, 2);
    expect_ev(2, w, 0, 2);
    expect_ev(3, w + 27, 0, 2);
    expect_ev(4, w + 43, 0, 2);
    expect_ev(5, w + 44, 0, 2);
    pulse_refclklost(p);
    step_to(w + 10);
    pll_lock_i = 1'b0;
    step_to(w + 11);
    pll_lock_i = 1'b1;
    drain(300);

    // Masked lanes: enabled lanes done is enough
    p = cyc;
    link_enable_i  = 4'b0101;
    tx_resetdone_i = 4'b0101;
    expect_ev(1, p + 1, 0, 3);
    expect_ev(2, p + 129, 0, 3);
    expect_ev(3, p + 145, 0, 3);
    expect_ev(4, p + 161, 0, 3);
    expect_ev(5, p + 162, 0, 3);
    pulse_refclklost(p);
    drain(300);

    // All lanes enabled with the same done pattern: WAIT_DONE timeout, then recovery
    p = cyc;
    link_enable_i = 4'b1111;
    expect_ev(1, p + 1, 0, 4);
    expect_ev(2, p + 129, 0, 4);
    expect_ev(3, p + 145, 0, 4);
    expect_ev(4, p + 161, 0, 4);
    expect_ev(0, p + 225, 1, 4);
    expect_ev(1, p + 321, 1, 4);
    expect_ev(2, p + 449, 1, 4);
    expect_ev(3, p + 465, 1, 4);
    expect_ev(4, p + 481, 1, 4);
    expect_ev(5, p + 482, 0, 4);
    pulse_refclklost(p);
    step_to(p + 300);
    tx_resetdone_i = 4'hF;
    drain(600);

    // Lock held low: two retries then FAULT
    p = cyc;
    expect_ev(1, p + 1, 0, 5);
    expect_ev(2, p + 129, 0, 5);
    expect_ev(0, p + 193, 1, 5);
    expect_ev(1, p + 289, 1, 5);
    expect_ev(2, p + 417, 1, 5);
    expect_ev(0, p + 481, 2, 5);
    expect_ev(1, p + 577, 2, 5);
    expect_ev(2, p + 705, 2, 5);
    expect_ev(6, p + 769, 2, 5);
    pll_lock_i = 1'b0;
    drain(900);
    step_to(cyc + 100);

    // Reset clears FAULT; then reset mid-WAIT_DONE restarts the count
    p = cyc;
    expect_ev(0, p + 1, 0, 0);
    reset_i        = 1'b1;
    pll_lock_i     = 1'b1;
    tx_resetdone_i = 4'h0;
    step_to(p + 1);
    reset_i = 1'b0;
    r = cyc;
    expect_ev(1, r + 96, 0, 0);
    expect_ev(2, r + 224, 0, 0);
    expect_ev(3, r + 240, 0, 0);
    expect_ev(4, r + 256, 0, 0);
    expect_ev(0, r + 257, 0, 0);
    step_to(r + 256);
    reset_i = 1'b1;
    step_to(r + 257);
    reset_i = 1'b0;
    tx_resetdone_i = 4'hF;
    r = cyc;
    expect_ev(1, r + 96, 0, 0);
    expect_ev(2, r + 224, 0, 0);
    expect_ev(3, r + 240, 0, 0);
    expect_ev(4, r + 256, 0, 0);
    expect_ev(5, r + 257, 0, 0);
    drain(400);
    step_to(cyc + 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_link_bringup_ctrl.md
Name: trigger_link_bringup_ctrl

Overview:
Power-up and recovery sequencer for the trigger-link transmit path. It steps the shared GTP common PLL through power-down, reset and lock, then resets the TX lanes and waits for their reset-done flags. It watches for loss of lock, retries on timeout and latches a fault after repeated failures. It sits beside the trigger-link wrapper and drives its PLL powerdown/reset and TX reset inputs in place of free-running counters.

Parameters:
ILINKS, 4, number of TX lanes supervised
PDCNT, 96, cycles spent in PWRDN
RSTCNT, 128, cycles spent in PLLRST
LOCK_STABLE, 16, consecutive locked cycles required in WAIT_LOCK
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK
TXRSTCNT, 16, cycles spent in TXRST
DONE_TIMEOUT, 4096, max cycles in WAIT_DONE
MAX_RETRIES, 7, timeouts tolerated before FAULT

Ports:
clk_40  in  1  sequencer clock; all logic on its rising edge
reset_i  in  1  synchronous, active-high reset
pll_lock_i  in  1  common PLL lock (already synchronised to clk_40)
pll_refclklost_i  in  1  common PLL refclk lost
mmcm_lock_i  in  1  logic MMCM lock
tx_resetdone_i  in  ILINKS  per-lane TX reset done
link_enable_i  in  ILINKS  1 = lane participates in WAIT_DONE
pll_powerdown_o  out  1  common PLL power-down
pll_reset_o  out  1  common PLL reset
tx_reset_o  out  1  TX lane reset (all lanes)
ready_o  out  1  links up
fault_o  out  1  retries exhausted
state_o  out  3  current state encoding
retry_cnt_o  out  4  timeouts since last READY
lock_loss_cnt_o  out  16  lock losses while READY, saturating

Behaviour:
- Clock and reset: one clock, clk_40. reset_i is synchronous and active-high.
- Registered outputs: all outputs are registered and are a function of the current state.
- Reset values: state = PWRDN, timer = 0, pll_powerdown_o = 1, pll_reset_o = 1, tx_reset_o = 1, ready_o = 0, fault_o = 0, retry_cnt_o = 0, lock_loss_cnt_o = 0.
- Reset mid-operation: asserting reset_i in any state, including FAULT, returns everything to these values on the next edge.
- Timer: one 16-bit timer, cleared on every state entry and incremented each cycle. "N cycles in state" means exit occurs on the cycle timer == N-1.
- States (state_o encoding) and output levels:
  - PWRDN (0): powerdown = 1, pll_reset = 1, tx_reset = 1. After PDCNT cycles -> PLLRST.
  - PLLRST (1): powerdown = 0, pll_reset = 1, tx_reset = 1. After RSTCNT cycles -> WAIT_LOCK.
  - WAIT_LOCK (2): pll_reset = 0, tx_reset = 1.
    - locked = pll_lock_i & mmcm_lock_i & ~pll_refclklost_i.
    - A stability counter increments while locked and clears when not locked.
    - On reaching LOCK_STABLE -> TXRST.
    - Otherwise, at timer == LOCK_TIMEOUT-1 -> timeout.
    - If stability is reached on the timeout cycle, success wins.
  - TXRST (3): tx_reset = 1. After TXRSTCNT cycles -> WAIT_DONE.
  - WAIT_DONE (4): tx_reset = 0.
    - Exit condition: &(tx_resetdone_i | ~link_enable_i) -> READY.
    - All lanes disabled: the condition is true immediately, so the state lasts one cycle.
    - At timer == DONE_TIMEOUT-1 without done -> timeout; done wins if simultaneous.
  - READY (5): ready_o = 1, all resets 0. retry_cnt cleared on entry.
    - Lock loss: ~locked for one cycle -> lock_loss_cnt++ (saturates at 0xFFFF) and go to PLLRST.
    - Lock loss does not increment retry_cnt.
  - FAULT (6): powerdown = 1, pll_reset = 1, tx_reset = 1, fault_o = 1. Held until reset_i.
- Timeout handling:
  - If retry_cnt == MAX_RETRIES -> FAULT.
  - Else retry_cnt++ and -> PWRDN, giving a full power cycle.
- Lane sampling: link_enable_i is sampled continuously. A lane that changes mid-WAIT_DONE takes effect on the next cycle.
- Unused encoding: 7 -> PWRDN.
- Latency:
  - Inputs to state change: 1 cycle.
  - State to outputs: same edge, since outputs are decoded from the next state and registered.

Test Plan:
- Clean bring-up: PDCNT = 96, RSTCNT = 128, lock held high, all resetdone high.
  - After reset_i falls: powerdown high exactly 96 cycles, pll_reset high 224 cycles.
  - ready_o rises 16 + 16 + 1 cycles after pll_reset falls.
  - retry_cnt_o = 0.
- Lock timeout: LOCK_TIMEOUT = 64, MAX_RETRIES = 2, pll_lock_i held 0.
  - Sequence revisits PWRDN twice with retry_cnt_o = 1 then 2.
  - Third timeout -> state_o = 6, fault_o = 1, all resets 1.
  - reset_i pulse clears the fault.
- Lock glitch: pll_lock_i drops for 1 cycle at stability count 10 in WAIT_LOCK.
  - Stability restarts; TXRST is entered 16 cycles after lock returns.
- Lane masking: link_enable_i = 4'b0101, tx_resetdone_i = 4'b0101 -> READY.
  - With enable = 4'b1111, the same input times out after DONE_TIMEOUT.
- Loss of lock in READY: pll_refclklost_i pulses 1 cycle.
  - lock_loss_cnt_o = 1, state_o = 1 next cycle, ready_o = 0.
  - READY is re-achieved and retry_cnt_o stays 0.
- Mid-sequence reset: reset_i asserted in WAIT_DONE.
  - Next cycle state_o = 0, all outputs at reset values.
  - The PDCNT count restarts from 0.
